// File: rtl/sqrt_iter_unit.sv
// sqrt_iter_unit
// Restoring digit-by-digit unsigned square root. One result bit is produced
// per clock. A start/ready/done handshake wraps the unit.
// The result is fixed point UQ(WIDTH/2).(FRAC_BITS). The fractional bits come
// from zero pairs that are shifted in after the radicand has been consumed.
// Optional feature: define SQRT_ROUND_EN to round q_out to the nearest value.
// When the macro is undefined, q_out is the truncated root and no rounding
// logic is built.

module sqrt_iter_unit #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [WIDTH-1:0]               d_in,
    output logic                           ready,
    output logic                           busy,
    output logic                           done,
    output logic [WIDTH/2+FRAC_BITS-1:0]   q_out,
    output logic [WIDTH/2+FRAC_BITS:0]     r_out
);

    localparam int QW = WIDTH / 2 + FRAC_BITS;
    localparam int N  = QW;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] d_reg;
    logic [QW+1:0]    r_reg;
    logic [QW-1:0]    q_reg;
    logic [CW-1:0]    count;

    logic [QW+1:0]    r_shift;
    logic [QW+1:0]    t_val;
    logic             take;
    logic [QW+1:0]    r_next;
    logic [QW-1:0]    q_next;
    logic [QW-1:0]    q_final;

    // The partial remainder never exceeds 2*Q. Its top two bits are always
    // zero before the shift, so dropping them in r_shift loses nothing.
    logic unused_r_top;
    assign unused_r_top = ^r_reg[QW+1:QW];

    // Handshake flags are decoded directly from the state register.
    always_comb begin
        ready = (state == IDLE);
        busy  = (state == CALC) || (state == DONE);
        done  = (state == DONE);
    end

    // One restoring iteration. Bring down the next radicand pair, then
    // trial-subtract {Q, 01}.
    always_comb begin
        r_shift = {r_reg[QW-1:0], d_reg[WIDTH-1 -: 2]};
        t_val   = {q_reg, 2'b01};
        take    = (r_shift >= t_val);
        r_next  = take ? (r_shift - t_val) : r_shift;
        q_next  = {q_reg[QW-2:0], take};
    end

    // Final root. With rounding, the root goes up by one when r > q. That
    // test is equivalent to sqrt > q + 0.5, and a tie is impossible. The
    // all-ones root saturates.
`ifdef SQRT_ROUND_EN
    always_comb begin
        q_final = q_next;
        if (({1'b0, q_next} < r_next[QW:0]) && !(&q_next))
            q_final = q_next + 1'b1;
    end
`else
    always_comb begin
        q_final = q_next;
    end
`endif

    // Control FSM and datapath registers. A reset at any point abandons the
    // current operation.
    // NOTE: every register here uses non-blocking assignment. All flops see
    // the pre-edge values, so r_next/q_next read this cycle's R and Q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            d_reg <= '0;
            r_reg <= '0;
            q_reg <= '0;
            count <= '0;
            q_out <= '0;
            r_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_reg <= d_in;
                        r_reg <= '0;
                        q_reg <= '0;
                        count <= CW'(N);
                        state <= CALC;
                    end
                end
                CALC: begin
                    d_reg <= {d_reg[WIDTH-3:0], 2'b00};
                    r_reg <= r_next;
                    q_reg <= q_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        q_out <= q_final;
                        r_out <= r_next[QW:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// tb_sqrt_iter_unit
// Directed bench for sqrt_iter_unit. It builds three instances:
//   u16: WIDTH=16, FRAC_BITS=0
//   u8:  WIDTH=8,  FRAC_BITS=0  (exhaustive sweep)
//   uf:  WIDTH=16, FRAC_BITS=4
// Rounded expectations apply when SQRT_ROUND_EN is defined for the build.

module tb_sqrt_iter_unit;

`ifdef SQRT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s16, rdy16, bsy16, dn16;
    logic [15:0] d16;
    logic [7:0]  q16;
    logic [8:0]  r16;

    logic        s8, rdy8, bsy8, dn8;
    logic [7:0]  d8;
    logic [3:0]  q8;
    logic [4:0]  r8;

    logic        sf, rdyf, bsyf, dnf;
    logic [15:0] df;
    logic [11:0] qf;
    logic [12:0] rf;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt_iter_unit #(.WIDTH(16), .FRAC_BITS(0)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .d_in(d16),
        .ready(rdy16), .busy(bsy16), .done(dn16), .q_out(q16), .r_out(r16));

    sqrt_iter_unit #(.WIDTH(8), .FRAC_BITS(0)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .d_in(d8),
        .ready(rdy8), .busy(bsy8), .done(dn8), .q_out(q8), .r_out(r8));

    sqrt_iter_unit #(.WIDTH(16), .FRAC_BITS(4)) uf (
        .clk(clk), .rst_n(rst_n), .start(sf), .d_in(df),
        .ready(rdyf), .busy(bsyf), .done(dnf), .q_out(qf), .r_out(rf));

    // Reference floor square root by linear search.
    function automatic longint isqrt(input longint x);
        longint q = 0;
        while ((q + 1) * (q + 1) <= x) q++;
        return q;
    endfunction

    // Rounded root from the truncated root and its remainder.
    function automatic longint round_q(input longint q, input longint r, input longint qmax);
        if (ROUND && (r > q) && (q != qmax)) return q + 1;
        return q;
    endfunction

    // One operation on u16. Returns the results and the number of edges from
    // the accepting edge to the first cycle with done high (-1 on timeout).
    task automatic op16(input logic [15:0] d, output logic [7:0] q, output logic [8:0] r,
                        output int lat);
        int i = 0;
        @(negedge clk);
        while (!rdy16 && i < 20) begin @(negedge clk); i++; end
        d16 = d; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0; d16 = ~d;
        lat = -1; i = 0;
        while (lat < 0 && i < 50) begin
            @(posedge clk); #1; i++;
            if (dn16) lat = i;
        end
        q = q16; r = r16;
    endtask

    task automatic op8(input logic [7:0] d, output logic [3:0] q, output logic [4:0] r,
                       output int lat);
        int i = 0;
        @(negedge clk);
        while (!rdy8 && i < 20) begin @(negedge clk); i++; end
        d8 = d; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0; d8 = ~d;
        lat = -1; i = 0;
        while (lat < 0 && i < 50) begin
            @(posedge clk); #1; i++;
            if (dn8) lat = i;
        end
        q = q8; r = r8;
    endtask

    task automatic opf(input logic [15:0] d, output logic [11:0] q, output logic [12:0] r,
                       output int lat);
        int i = 0;
        @(negedge clk);
        while (!rdyf && i < 20) begin @(negedge clk); i++; end
        df = d; sf = 1'b1;
        @(posedge clk); #1;
        sf = 1'b0; df = ~d;
        lat = -1; i = 0;
        while (lat < 0 && i < 50) begin
            @(posedge clk); #1; i++;
            if (dnf) lat = i;
        end
        q = qf; r = rf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rdy16 !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", rdy16); end
        n_cmp++; if (bsy16 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bsy16); end
        n_cmp++; if (dn16 !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", dn16); end
        n_cmp++; if (q16 !== 8'd0) begin n_bad++; $display("FAIL reset_q got=%0d exp=0", q16); end
        n_cmp++; if (r16 !== 9'd0) begin n_bad++; $display("FAIL reset_r got=%0d exp=0", r16); end
        n_cmp++; if ({rdy8, rdyf} !== 2'b11) begin n_bad++; $display("FAIL reset_ready_others got=%b exp=11", {rdy8, rdyf}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Hand-computed truncated roots and remainders for 16-bit operands.
    task automatic test_basic16();
        logic [15:0] dv [11] = '{16'd144, 16'd0, 16'hFFFF, 16'd1, 16'd2, 16'd3,
                                 16'd255, 16'd256, 16'd1000, 16'h8000, 16'hFFFE};
        int qv [11] = '{12, 0, 255, 1, 1, 1, 15, 16, 31, 181, 255};
        int rv [11] = '{0, 0, 510, 0, 1, 2, 30, 0, 39, 7, 509};
        logic [7:0] q; logic [8:0] r; int lat;
        logic [7:0] eq;
        for (int i = 0; i < 11; i++) begin
            op16(dv[i], q, r, lat);
            eq = 8'(round_q(qv[i], rv[i], 255));
            n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency d=%0d got=%0d exp=8", dv[i], lat); end
            n_cmp++; if (q !== eq) begin n_bad++; $display("FAIL basic_q d=%0d got=%0d exp=%0d", dv[i], q, eq); end
            n_cmp++; if (r !== 9'(rv[i])) begin n_bad++; $display("FAIL basic_r d=%0d got=%0d exp=%0d", dv[i], r, rv[i]); end
        end
    endtask

    // Zero operand: done must last exactly one cycle, and ready must return
    // in the cycle after it.
    task automatic test_done_pulse();
        logic [7:0] q; logic [8:0] r; int lat;
        op16(16'd0, q, r, lat);
        n_cmp++; if (dn16 !== 1'b1) begin n_bad++; $display("FAIL pulse_high got=%b exp=1", dn16); end
        n_cmp++; if (bsy16 !== 1'b1 || rdy16 !== 1'b0) begin n_bad++; $display("FAIL pulse_flags busy=%b ready=%b exp busy=1 ready=0", bsy16, rdy16); end
        @(posedge clk); #1;
        n_cmp++; if (dn16 !== 1'b0) begin n_bad++; $display("FAIL pulse_width got=%b exp=0", dn16); end
        n_cmp++; if (rdy16 !== 1'b1) begin n_bad++; $display("FAIL pulse_ready got=%b exp=1", rdy16); end
        n_cmp++; if (q16 !== 8'd0 || r16 !== 9'd0) begin n_bad++; $display("FAIL pulse_result q=%0d r=%0d exp=0/0", q16, r16); end
    endtask

    // The previous results must hold through a new operation until it ends.
    task automatic test_hold_outputs();
        logic [7:0] q; logic [8:0] r; int lat;
        op16(16'd144, q, r, lat);
        @(negedge clk); @(negedge clk);
        d16 = 16'd1000; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bsy16 !== 1'b1) begin n_bad++; $display("FAIL hold_busy got=%b exp=1", bsy16); end
        n_cmp++; if (q16 !== 8'd12 || r16 !== 9'd0) begin n_bad++; $display("FAIL hold_result q=%0d r=%0d exp=12/0", q16, r16); end
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (q16 !== 8'(round_q(31, 39, 255)) || r16 !== 9'd39) begin n_bad++; $display("FAIL hold_next q=%0d r=%0d exp=31/39", q16, r16); end
    endtask

    // Start is held high while d_in changes every cycle. Only the values
    // present at accepting edges may be used.
    task automatic test_back_to_back();
        logic [15:0] vals [7] = '{16'd50000, 16'd9, 16'd12345, 16'd777, 16'hFFFF, 16'd4097, 16'd64};
        logic [15:0] pend [$];
        logic [15:0] x;
        longint eq, er;
        int n_done = 0;
        int budget = 0;
        @(negedge clk);
        s16 = 1'b1;
        for (int c = 0; c < 45; c++) begin
            if (c > 0) @(negedge clk);
            d16 = vals[c % 7];
            if (rdy16) pend.push_back(d16);
            @(posedge clk); #1;
            if (dn16) begin
                n_cmp++;
                if (pend.size() == 0) begin n_bad++; $display("FAIL b2b_spurious_done got=1 exp=0"); end
                else begin
                    x = pend.pop_front();
                    eq = isqrt(x); er = x - eq * eq; eq = round_q(eq, er, 255);
                    if (q16 !== 8'(eq) || r16 !== 9'(er)) begin
                        n_bad++; $display("FAIL b2b_result d=%0d got q=%0d r=%0d exp q=%0d r=%0d", x, q16, r16, eq, er);
                    end
                    n_done++;
                end
            end
        end
        @(negedge clk);
        s16 = 1'b0;
        while (pend.size() != 0 && budget < 30) begin
            @(posedge clk); #1; budget++;
            if (dn16) begin
                x = pend.pop_front();
                eq = isqrt(x); er = x - eq * eq; eq = round_q(eq, er, 255);
                n_cmp++;
                if (q16 !== 8'(eq) || r16 !== 9'(er)) begin
                    n_bad++; $display("FAIL b2b_drain d=%0d got q=%0d r=%0d exp q=%0d r=%0d", x, q16, r16, eq, er);
                end
                n_done++;
            end
        end
        n_cmp++; if (pend.size() != 0) begin n_bad++; $display("FAIL b2b_pending got=%0d exp=0", pend.size()); end
        n_cmp++; if (n_done < 4) begin n_bad++; $display("FAIL b2b_count got=%0d exp>=4", n_done); end
    endtask

    // Fractional instance. For d=2, d*256=512, so the root is 22 (0x16)
    // with r=28. For 0xFFFF, d*256=16776960, so q=4095 and r=7935.
    task automatic test_frac();
        logic [15:0] dv [4] = '{16'd2, 16'hFFFF, 16'd0, 16'd1};
        int qv [4] = '{22, 4095, 0, 16};
        int rv [4] = '{28, 7935, 0, 0};
        logic [11:0] q; logic [12:0] r; int lat;
        logic [11:0] eq;
        for (int i = 0; i < 4; i++) begin
            opf(dv[i], q, r, lat);
            eq = 12'(round_q(qv[i], rv[i], 4095));
            n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL frac_latency d=%0d got=%0d exp=12", dv[i], lat); end
            n_cmp++; if (q !== eq) begin n_bad++; $display("FAIL frac_q d=%0d got=%h exp=%h", dv[i], q, eq); end
            n_cmp++; if (r !== 13'(rv[i])) begin n_bad++; $display("FAIL frac_r d=%0d got=%0d exp=%0d", dv[i], r, rv[i]); end
        end
    endtask

    // Reset asserted during the 4th CALC cycle aborts the operation.
    task automatic test_reset_mid();
        logic [7:0] q; logic [8:0] r; int lat;
        logic saw_done = 1'b0;
        op16(16'd1000, q, r, lat);
        @(negedge clk); @(negedge clk);
        d16 = 16'd144; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (rdy16 !== 1'b1 || bsy16 !== 1'b0) begin n_bad++; $display("FAIL midrst_flags ready=%b busy=%b exp 1/0", rdy16, bsy16); end
        n_cmp++; if (q16 !== 8'd0 || r16 !== 9'd0) begin n_bad++; $display("FAIL midrst_result q=%0d r=%0d exp=0/0", q16, r16); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (dn16) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b exp=0", saw_done); end
    endtask

    // Every 8-bit operand on the narrow instance.
    task automatic test_sweep8();
        logic [3:0] q; logic [4:0] r; int lat;
        longint eq, er;
        for (int x = 0; x < 256; x++) begin
            op8(8'(x), q, r, lat);
            eq = isqrt(x); er = x - eq * eq; eq = round_q(eq, er, 15);
            n_cmp++;
            if (lat !== 4 || q !== 4'(eq) || r !== 5'(er)) begin
                n_bad++; $display("FAIL sweep8 d=%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=4", x, q, r, lat, eq, er);
            end
        end
    endtask

    initial begin
        s16 = 1'b0; d16 = '0;
        s8  = 1'b0; d8  = '0;
        sf  = 1'b0; df  = '0;
        rst_n = 1'b1;
        test_reset();
        test_basic16();
        test_done_pulse();
        test_hold_outputs();
        test_back_to_back();
        test_frac();
        test_reset_mid();
        test_sweep8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
